key_debounce: RTL

//  Input-side companion to the LED output drivers. Takes raw active-low push-button

---
 rtl/key_debounce_pkg.sv | 23 ++
 rtl/key_debounce_if.sv | 28 ++
 rtl/key_debounce_ch.sv | 145 ++++++++++++++
 rtl/key_debounce.sv | 36 +++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// key_pkg: shared types and default timing for the key debouncer.
//   key_state_t : per-channel debounce FSM state encoding
//   *_DEF       : default timing constants for a 50 MHz sys_clk
//   cnt_width() : counter width able to hold 0 .. n-1 (never below 1 bit)
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int unsigned KEY_NUM_DEF      = 4;
  localparam int unsigned DEBOUNCE_CNT_DEF = 1_000_000;   // 20 ms
  localparam int unsigned REPEAT_DLY_DEF   = 25_000_000;  // 0.5 s
  localparam int unsigned REPEAT_PER_DEF   = 5_000_000;   // 0.1 s

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: key-side bundle between the board keys and the debouncer.
//   key_in      raw keys, active low (0 = pressed)
//   key_level   debounced state, 1 = pressed
//   key_press   1-cycle strobe per debounced press
//   key_release 1-cycle strobe per debounced release
//   key_repeat  1-cycle auto-repeat strobe while held
// Modports: master = key source / consumer of strobes, slave = debouncer.
interface key_debounce_if import key_pkg::*; #(
  parameter int unsigned KEY_NUM = KEY_NUM_DEF
);

  logic [KEY_NUM-1:0] key_in;
  logic [KEY_NUM-1:0] key_level;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] key_release;
  logic [KEY_NUM-1:0] key_repeat;

  modport master (
    output key_in,
    input  key_level, key_press, key_release, key_repeat
  );

  modport slave (
    input  key_in,
    output key_level, key_press, key_release, key_repeat
  );

endinterface

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel - 2-FF synchroniser, debounce FSM,
// debounce counter and (optionally) auto-repeat counter.
// Build option: KEY_DEBOUNCE_REPEAT_EN builds the repeat counter; otherwise
// key_repeat is tied low.
// Ports:
//   sys_clk, sys_rst_n  clock, async active-low reset
//   key_in              raw key, asynchronous, active low
//   key_level           debounced state, 1 = pressed
//   key_press           1-cycle strobe on debounced press
//   key_release         1-cycle strobe on debounced release
//   key_repeat          1-cycle repeat strobe while held
//
// state        | meaning
// -------------+-------------------------------------------------
// IDLE         | key released and stable
// PRESS_WAIT   | synchronised key low, counting stable cycles
// HELD         | debounced press, key still low
// RELEASE_WAIT | synchronised key high while pressed, counting
module key_debounce_ch import key_pkg::*; #(
  parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int unsigned REPEAT_DLY   = REPEAT_DLY_DEF,
  parameter int unsigned REPEAT_PER   = REPEAT_PER_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  if (DEBOUNCE_CNT < 1) begin : g_bad_db
    $error("key_debounce_ch: DEBOUNCE_CNT must be at least 1");
  end
  if (REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_rpt
    $error("key_debounce_ch: REPEAT_DLY and REPEAT_PER must be at least 1");
  end

  localparam int unsigned   DW      = cnt_width(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CNT - 1);

  logic          sync_q1;
  logic          ks;
  key_state_t    state;
  key_state_t    state_nxt;
  logic [DW-1:0] db_cnt;
  logic          db_done;

  // Released (1) is the reset value so a key held through reset is seen as
  // a fresh falling edge afterwards.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q1 <= 1'b1;
      ks      <= 1'b1;
    end else begin
      sync_q1 <= key_in;
      ks      <= sync_q1;
    end
  end

  assign db_done = (db_cnt == DB_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state  <= IDLE;
      db_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        db_cnt <= '0;
      else if (state == PRESS_WAIT || state == RELEASE_WAIT)
        db_cnt <= db_cnt + DW'(1);
    end
  end

  // Strobes are decoded in the cycle the terminal count is seen, which is
  // what gives the 2 + DEBOUNCE_CNT cycle latency from the raw edge.
  always_comb begin
    state_nxt   = state;
    key_press   = 1'b0;
    key_release = 1'b0;
    case (state)
      IDLE: begin
        if (!ks) state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (ks) begin
          state_nxt = IDLE;
        end else if (db_done) begin
          state_nxt = HELD;
          key_press = 1'b1;
        end
      end
      HELD: begin
        if (ks) state_nxt = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!ks) begin
          state_nxt = HELD;
        end else if (db_done) begin
          state_nxt   = IDLE;
          key_release = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    key_level = (state == HELD) || key_press ||
                ((state == RELEASE_WAIT) && !key_release);
  end

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int unsigned RPT_W = cnt_width((REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER);

  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_last;
  logic             rpt_periodic;
  logic             rpt_hit;

  // First HELD cycle is one after key_press, so a terminal count of
  // REPEAT_DLY-1 lands the first strobe REPEAT_DLY cycles after the press.
  assign rpt_last = rpt_periodic ? RPT_W'(REPEAT_PER - 1) : RPT_W'(REPEAT_DLY - 1);
  assign rpt_hit  = (state == HELD) && (rpt_cnt == rpt_last);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rpt_cnt      <= '0;
      rpt_periodic <= 1'b0;
    end else if (state != HELD) begin
      rpt_cnt      <= '0;
      rpt_periodic <= 1'b0;
    end else if (rpt_hit) begin
      rpt_cnt      <= '0;
      rpt_periodic <= 1'b1;
    end else begin
      rpt_cnt <= rpt_cnt + RPT_W'(1);
    end
  end

  assign key_repeat = rpt_hit;
`else
  assign key_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// key_debounce: debounces KEY_NUM raw active-low push buttons into
// per-key level, press, release and auto-repeat strobes on sys_clk.
// Build option: KEY_DEBOUNCE_REPEAT_EN enables the auto-repeat strobes;
// without it key_repeat is constant 0.
// Ports:
//   sys_clk    system clock
//   sys_rst_n  async active-low reset
//   key_bus    key_debounce_if.slave (key_in in; level/press/release/repeat out)
module key_debounce import key_pkg::*; #(
  parameter int unsigned KEY_NUM      = KEY_NUM_DEF,
  parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int unsigned REPEAT_DLY   = REPEAT_DLY_DEF,
  parameter int unsigned REPEAT_PER   = REPEAT_PER_DEF
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  key_debounce_if.slave  key_bus
);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .REPEAT_DLY   (REPEAT_DLY),
      .REPEAT_PER   (REPEAT_PER)
    ) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .key_in      (key_bus.key_in[i]),
      .key_level   (key_bus.key_level[i]),
      .key_press   (key_bus.key_press[i]),
      .key_release (key_bus.key_release[i]),
      .key_repeat  (key_bus.key_repeat[i])
    );
  end

endmodule
